// File: rtl/instr_fetch_pkg.sv
// Shared CPU constants: PC-module select encodings, fetch FSM states
// and the CB prefix opcode.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    OFFSET_HOLD = 2'd0,
    OFFSET_INCR = 2'd1,
    OFFSET_ZERO = 2'd2
  } offset_sel_t;

  typedef enum logic [2:0] {
    PC_SEL_PC           = 3'd0,
    PC_SEL_PC_INCR      = 3'd1,
    PC_SEL_RST          = 3'd2,
    PC_SEL_INT          = 3'd3,
    PC_SEL_ZERO         = 3'd4,
    PC_SEL_DATA_BUS     = 3'd5,
    PC_SEL_DATA_BUS_REL = 3'd6
  } pc_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FETCH_OP  = 2'd1,
    ST_FETCH_IMM = 2'd2,
    ST_HOLD      = 2'd3
  } fetch_state_t;

  localparam logic [7:0] CB_PREFIX = 8'hCB;

endpackage

// File: rtl/opcode_len.sv
// Combinational opcode -> instruction length (1..3 bytes) lookup,
// shared between fetch and decode.
module opcode_len
  import instr_fetch_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] len
);

  always_comb begin
    len = 2'd1;
    case (opcode)
      8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hC2, 8'hC3, 8'hC4, 8'hCA,
      8'hCC, 8'hCD, 8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA, 8'hFA:
        len = 2'd3;
      8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'h10,
      8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'hC6, 8'hCE, 8'hD6, 8'hDE,
      8'hE6, 8'hEE, 8'hF6, 8'hFE, 8'hE0, 8'hF0, 8'hE8, 8'hF8, CB_PREFIX:
        len = 2'd2;
      default:
        len = 2'd1;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: walks the PC offset across opcode and immediates,
// then holds the assembled instruction until the decoder accepts it.
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic        flush,
  input  logic [15:0] pc_w_offset,
  output logic [1:0]  offset_sel,
  output logic        pc_incr,
  output logic [15:0] mem_addr,
  output logic        mem_rd_req,
  input  logic        mem_rd_ack,
  input  logic [7:0]  mem_rd_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  opcode,
  output logic        cb_prefix,
  output logic [15:0] imm,
  output logic [1:0]  instr_len
);

  fetch_state_t state_reg, state_next;
  logic [7:0]   opcode_reg;
  logic [15:0]  imm_reg;
  logic [1:0]   len_reg;
  logic         cb_reg;
  logic         imm_cnt_reg;
  logic [1:0]   rd_len;
  logic         fetching;
  logic         last_byte;

  opcode_len u_opcode_len (
    .opcode (mem_rd_data),
    .len    (rd_len)
  );

  assign fetching = (state_reg == ST_FETCH_OP) || (state_reg == ST_FETCH_IMM);

  // The byte being read now completes the instruction, so the offset must stay put.
  always_comb begin
    last_byte = 1'b0;
    if (state_reg == ST_FETCH_OP)
      last_byte = (rd_len == 2'd1);
    else if (state_reg == ST_FETCH_IMM)
      last_byte = imm_cnt_reg || (len_reg == 2'd2);
  end

  always_comb begin
    state_next = state_reg;
    offset_sel = OFFSET_HOLD;
    pc_incr    = 1'b0;
    if (reset || flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (fetch_start) begin
            state_next = ST_FETCH_OP;
            offset_sel = OFFSET_ZERO;
          end
        end
        ST_FETCH_OP, ST_FETCH_IMM: begin
          if (mem_rd_ack) begin
            if (last_byte) state_next = ST_HOLD;
            else begin
              state_next = ST_FETCH_IMM;
              offset_sel = OFFSET_INCR;
            end
          end
        end
        ST_HOLD: begin
          if (instr_ready) begin
            pc_incr    = 1'b1;
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      opcode_reg  <= 8'h00;
      imm_reg     <= 16'h0000;
      len_reg     <= 2'd0;
      cb_reg      <= 1'b0;
      imm_cnt_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (!flush && mem_rd_ack) begin
        if (state_reg == ST_FETCH_OP) begin
          opcode_reg  <= mem_rd_data;
          imm_reg     <= 16'h0000;
          len_reg     <= rd_len;
          cb_reg      <= (mem_rd_data == CB_PREFIX);
          imm_cnt_reg <= 1'b0;
        end else if (state_reg == ST_FETCH_IMM) begin
          if (imm_cnt_reg) imm_reg[15:8] <= mem_rd_data;
          else             imm_reg[7:0]  <= mem_rd_data;
          imm_cnt_reg <= 1'b1;
        end
      end
    end
  end

  assign mem_rd_req  = fetching;
  assign mem_addr    = fetching ? pc_w_offset : 16'h0000;
  assign instr_valid = (state_reg == ST_HOLD);
  assign opcode      = opcode_reg;
  assign imm         = imm_reg;
  assign instr_len   = len_reg;
  assign cb_prefix   = cb_reg;

endmodule
